// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder
// Two-flop synchronizer, debounce state machine and one-hot-to-code encoder
// for the 20 calculator pushbuttons. Produces the debounced key-valid level
// (keyclk), the accepted key code (keyout), a one-cycle press strobe
// (key_pulse) and a multiple-keys-down flag (multi_key).
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
module key_debounce_encoder #(
   parameter int unsigned NUM_KEYS        = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 64,
   parameter int unsigned REPEAT_PERIOD   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] buttons,
   output logic [4:0]          keyout,
   output logic                keyclk,
   output logic                key_pulse,
   output logic                multi_key
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned POP_W = $clog2(NUM_KEYS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject parameter values the counters cannot represent.
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
   end
   if (NUM_KEYS > 32) begin : g_bad_keys
      $error("NUM_KEYS must fit a 5-bit code");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_PRESSED,
      ST_DEB_RELEASE
   } state_t;

   state_t              r_state;
   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [CNT_W-1:0]    r_cnt;
   logic [4:0]          r_cand;

   logic [POP_W-1:0]    w_ones;
   logic [4:0]          w_idx;
   logic                w_single;
   logic                w_match;
   logic                w_zero;
   logic [NUM_KEYS-1:0] w_cand_hot;

`ifdef KEY_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_first;
   logic             r_rep_restore;
   logic [REP_W-1:0] w_rep_last;
`endif

   // Population count and index of the synchronized button vector.
   always_comb begin
      w_ones = '0;
      w_idx  = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         w_ones = w_ones + POP_W'(r_sync2[i]);
         if (r_sync2[i]) begin
            w_idx = 5'(i);
         end
      end
      w_single   = (w_ones == POP_W'(1));
      w_cand_hot = NUM_KEYS'(1) << r_cand;
      w_match    = (r_sync2 == w_cand_hot);
      w_zero     = (r_sync2 == '0);
   end

`ifdef KEY_REPEAT_EN
   // Terminal count of the repeat counter: initial delay first, then the period.
   always_comb begin
      w_rep_last = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
   end
`endif

   // Synchronizer, debounce FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cand    <= '0;
         keyout    <= '0;
         keyclk    <= 1'b0;
         key_pulse <= 1'b0;
         multi_key <= 1'b0;
`ifdef KEY_REPEAT_EN
         r_rep_cnt     <= '0;
         r_rep_first   <= 1'b0;
         r_rep_restore <= 1'b0;
`endif
      end else begin
         r_sync1   <= buttons;
         r_sync2   <= r_sync1;
         multi_key <= (w_ones > POP_W'(1));
         key_pulse <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  r_state <= ST_DEB_PRESS;
                  r_cand  <= w_idx;
                  r_cnt   <= '0;
               end
            end

            ST_DEB_PRESS: begin
               if (w_match) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state   <= ST_PRESSED;
                     keyout    <= r_cand;
                     keyclk    <= 1'b1;
                     key_pulse <= 1'b1;
`ifdef KEY_REPEAT_EN
                     r_rep_cnt     <= '0;
                     r_rep_first   <= 1'b1;
                     r_rep_restore <= 1'b0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_PRESSED: begin
               if (!w_match) begin
                  r_state <= ST_DEB_RELEASE;
                  r_cnt   <= '0;
`ifdef KEY_REPEAT_EN
                  r_rep_cnt     <= '0;
                  r_rep_first   <= 1'b1;
                  r_rep_restore <= 1'b0;
`endif
               end else begin
`ifdef KEY_REPEAT_EN
                  // Repeat: drop keyclk for one cycle, then raise it with a new strobe.
                  if (r_rep_restore) begin
                     keyclk        <= 1'b1;
                     key_pulse     <= 1'b1;
                     r_rep_restore <= 1'b0;
                     r_rep_first   <= 1'b0;
                     r_rep_cnt     <= '0;
                  end else if (r_rep_cnt == w_rep_last) begin
                     keyclk        <= 1'b0;
                     r_rep_restore <= 1'b1;
                  end else begin
                     r_rep_cnt <= r_rep_cnt + 1'b1;
                  end
`endif
               end
            end

            ST_DEB_RELEASE: begin
               if (w_zero) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= ST_IDLE;
                     keyclk  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else if (w_match) begin
                  r_state <= ST_PRESSED;
`ifdef KEY_REPEAT_EN
                  // A release that began during a repeat low phase restores the held level.
                  keyclk  <= 1'b1;
`endif
               end else begin
                  r_cnt <= '0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
